// File: rtl/code_entry_lock.sv
// code_entry_lock: debounced digit-entry front end driving open/fail levels.
// Optional failure lockout is built only when CODE_LOCKOUT_EN is defined.
module code_entry_lock_db #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_q <= level;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pulse = level & ~level_q;

endmodule

module code_entry_lock #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned DIGIT_W        = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] CODE = 16'h1234,
  parameter int unsigned DB_CYCLES      = 1000000,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 500000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] sw,
  input  logic               btn_enter,
  input  logic               btn_clear,
  input  logic               btn_lock,
  output logic               open,
  output logic               fail,
  output logic               entry_active,
  output logic [3:0]         digit_cnt,
  output logic [3:0]         fail_cnt,
  output logic               locked_out
);

  localparam int unsigned W = DIGITS * DIGIT_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_FAIL
  } state_t;

  state_t             state;
  logic [W-1:0]       entry;
  logic [DIGIT_W-1:0] sw_s1;
  logic [DIGIT_W-1:0] sw_s2;
  logic               enter_p;
  logic               clear_p;
  logic               lock_p;
  logic               blocked;
  logic               do_enter;
  logic               do_clear;
  logic [3:0]         fail_nxt;
  logic               last_digit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  code_entry_lock_db #(.CYCLES(DB_CYCLES)) u_db_enter (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_enter),
    .pulse(enter_p)
  );

  code_entry_lock_db #(.CYCLES(DB_CYCLES)) u_db_clear (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_clear),
    .pulse(clear_p)
  );

  code_entry_lock_db #(.CYCLES(DB_CYCLES)) u_db_lock (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_lock),
    .pulse(lock_p)
  );

  // Lock outranks clear, clear outranks enter.
  assign do_clear   = clear_p & ~lock_p & ~blocked;
  assign do_enter   = enter_p & ~clear_p & ~lock_p & ~blocked;
  assign fail_nxt   = (fail_cnt == 4'hF) ? 4'hF : fail_cnt + 4'd1;
  assign last_digit = ((digit_cnt + 4'd1) == 4'(DIGITS));

  assign entry_active = (state == S_ENTRY);

`ifdef CODE_LOCKOUT_EN
  localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

  logic [LW-1:0] lock_timer;
  logic          lock_trip;

  assign blocked   = locked_out;
  assign lock_trip = (32'(fail_nxt) >= MAX_FAIL);
`else
  assign blocked    = 1'b0;
  assign locked_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      entry     <= '0;
      digit_cnt <= '0;
      open      <= 1'b0;
      fail      <= 1'b0;
      fail_cnt  <= '0;
`ifdef CODE_LOCKOUT_EN
      locked_out <= 1'b0;
      lock_timer <= '0;
`endif
    end else begin
`ifdef CODE_LOCKOUT_EN
      if (locked_out) begin
        if (lock_timer <= LW'(1)) begin
          locked_out <= 1'b0;
          lock_timer <= '0;
          fail_cnt   <= '0;
        end else begin
          lock_timer <= lock_timer - 1'b1;
        end
      end
`endif
      if (lock_p) begin
        state     <= S_IDLE;
        open      <= 1'b0;
        fail      <= 1'b0;
        digit_cnt <= '0;
        entry     <= '0;
      end else begin
        unique case (state)
          S_IDLE, S_ENTRY, S_FAIL: begin
            if (do_clear) begin
              if (state == S_ENTRY) begin
                state     <= S_IDLE;
                digit_cnt <= '0;
                entry     <= '0;
              end else if (state == S_FAIL) begin
                state <= S_IDLE;
                fail  <= 1'b0;
              end
            end else if (do_enter) begin
              entry     <= (entry << DIGIT_W) | W'(sw_s2);
              digit_cnt <= digit_cnt + 4'd1;
              fail      <= 1'b0;
              state     <= last_digit ? S_CHECK : S_ENTRY;
            end
          end
          S_CHECK: begin
            digit_cnt <= '0;
            entry     <= '0;
            if (entry == CODE) begin
              state    <= S_OPEN;
              open     <= 1'b1;
              fail_cnt <= '0;
            end else begin
              state    <= S_FAIL;
              fail     <= 1'b1;
              fail_cnt <= fail_nxt;
`ifdef CODE_LOCKOUT_EN
              if (lock_trip) begin
                locked_out <= 1'b1;
                lock_timer <= LW'(LOCKOUT_CYCLES);
              end
`endif
            end
          end
          S_OPEN: begin
            state <= S_OPEN;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_code_entry_lock.sv
// tb_code_entry_lock: directed and random button sequences against a
// digit-queue reference model of the lock.
module tb_code_entry_lock;

  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 4;
  localparam int DB      = 4;
  localparam logic [15:0] CODE = 16'h1234;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn_enter;
  logic       btn_clear;
  logic       btn_lock;
  logic       open;
  logic       fail;
  logic       entry_active;
  logic [3:0] digit_cnt;
  logic [3:0] fail_cnt;
  logic       locked_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  code_entry_lock #(
    .DIGITS        (DIGITS),
    .DIGIT_W       (DIGIT_W),
    .CODE          (CODE),
    .DB_CYCLES     (DB),
    .MAX_FAIL      (3),
    .LOCKOUT_CYCLES(50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .btn_enter   (btn_enter),
    .btn_clear   (btn_clear),
    .btn_lock    (btn_lock),
    .open        (open),
    .fail        (fail),
    .entry_active(entry_active),
    .digit_cnt   (digit_cnt),
    .fail_cnt    (fail_cnt),
    .locked_out  (locked_out)
  );

  // Reference model: digits typed so far plus verdict flags.
  int q[$];
  bit m_open;
  bit m_fail;
  int m_fcnt;

  function automatic int code_digit(int i);
    return int'(CODE >> ((DIGITS - 1 - i) * DIGIT_W)) & 15;
  endfunction

  function automatic void m_reset();
    q.delete();
    m_open = 0;
    m_fail = 0;
    m_fcnt = 0;
  endfunction

  function automatic void m_enter(int d);
    bit ok;
    if (m_open) return;
    m_fail = 0;
    q.push_back(d);
    if (q.size() == DIGITS) begin
      ok = 1;
      foreach (q[i]) if (q[i] != code_digit(i)) ok = 0;
      if (ok) begin
        m_open = 1;
        m_fcnt = 0;
      end else begin
        m_fail = 1;
        if (m_fcnt < 15) m_fcnt++;
      end
      q.delete();
    end
  endfunction

  function automatic void m_clear();
    if (m_open) return;
    if (q.size() > 0) q.delete();
    else if (m_fail) m_fail = 0;
  endfunction

  function automatic void m_lock();
    m_open = 0;
    m_fail = 0;
    q.delete();
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".open"}, open, m_open);
    check({tag, ".fail"}, fail, m_fail);
    check({tag, ".active"}, entry_active, q.size() > 0);
    check({tag, ".digits"}, digit_cnt, q.size());
    check({tag, ".fcnt"}, fail_cnt, m_fcnt);
    check({tag, ".locked"}, locked_out, 0);
  endtask

  // Clean press: hold long enough to debounce, then release and settle.
  task automatic press(bit e, bit c, bit l, int d);
    sw        = 4'(d);
    btn_enter = e;
    btn_clear = c;
    btn_lock  = l;
    repeat (DB + 3) @(negedge clk);
    btn_enter = 0;
    btn_clear = 0;
    btn_lock  = 0;
    repeat (DB + 6) @(negedge clk);
  endtask

  task automatic enter_code(logic [15:0] c);
    int d;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(c >> ((DIGITS - 1 - i) * DIGIT_W)) & 15;
      press(1, 0, 0, d);
      m_enter(d);
    end
  endtask

  initial begin
    int lat;
    int r;
    int d;
    rst       = 0;
    sw        = 0;
    btn_enter = 0;
    btn_clear = 0;
    btn_lock  = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1;
    repeat (2) @(negedge clk);

    // Latency: 2 sync + DB debounce + pulse-to-CHECK + CHECK-to-OPEN.
    for (int i = 1; i <= 3; i++) begin
      press(1, 0, 0, i);
      m_enter(i);
    end
    sw        = 4'd4;
    btn_enter = 1;
    lat       = 0;
    while (!open && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("open_latency", lat, 2 + DB + 2);
    btn_enter = 0;
    repeat (DB + 6) @(negedge clk);
    m_enter(4);
    check_all("code_1234");

    press(0, 0, 1, 0);
    m_lock();
    check_all("lock_open");

    enter_code(16'h1235);
    check_all("wrong");
    press(1, 0, 0, 1);
    m_enter(1);
    check_all("fail_drop");
    press(1, 0, 0, 2);
    m_enter(2);
    press(1, 0, 0, 3);
    m_enter(3);
    press(1, 0, 0, 4);
    m_enter(4);
    check_all("retry");

    press(0, 0, 1, 0);
    m_lock();
    sw = 4'd7;
    for (int i = 0; i < 5; i++) begin
      btn_enter = 1;
      repeat (2) @(negedge clk);
      btn_enter = 0;
      repeat (2) @(negedge clk);
    end
    btn_enter = 1;
    repeat (10) @(negedge clk);
    btn_enter = 0;
    repeat (DB + 6) @(negedge clk);
    m_enter(7);
    check_all("bounce");

    press(0, 1, 0, 0);
    m_clear();
    press(1, 0, 0, 1);
    m_enter(1);
    press(1, 0, 0, 2);
    m_enter(2);
    press(0, 1, 0, 0);
    m_clear();
    check_all("clear");
    enter_code(16'h1234);
    check_all("after_clear");

    press(1, 0, 1, 5);
    m_lock();
    check_all("lock_beats_enter");

    press(1, 0, 0, 1);
    m_enter(1);
    press(1, 0, 0, 2);
    m_enter(2);
    #2 rst = 0;
    #1 m_reset();
    check_all("rst_mid_entry");
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    enter_code(16'h1234);
    #2 rst = 0;
    #1 m_reset();
    check_all("rst_open");
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);

`ifdef CODE_LOCKOUT_EN
    enter_code(16'h1235);
    enter_code(16'h9999);
    enter_code(16'h1235);
    check("lo_fcnt3", fail_cnt, 3);
    check("lo_on", locked_out, 1);
    press(1, 0, 0, 1);
    check("lo_ignored_digits", digit_cnt, 0);
    check("lo_still_on", locked_out, 1);
    lat = 0;
    while (locked_out && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("lo_expired", locked_out, 0);
    check("lo_fcnt_clr", fail_cnt, 0);
    m_fcnt = 0;
    enter_code(16'h1234);
    check_all("lo_open");
`else
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        press(0, 0, 1, 0);
        m_lock();
      end else if (r == 1) begin
        press(0, 1, 0, 0);
        m_clear();
      end else begin
        if ($urandom_range(0, 1) == 1) d = code_digit(q.size());
        else d = $urandom_range(0, 15);
        press(1, 0, 0, d);
        m_enter(d);
      end
      check_all($sformatf("rnd%0d", k));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
